// File: rtl/check_scan_ctrl_pkg.sv
// ============================================================================
// Module   : check_scan_ctrl_pkg
// Brief    : Shared state encoding and segment index constants for the
//            debug check-data scan controller and the segment mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package check_scan_ctrl_pkg;

  // Controller states; the encoding is fixed so debug tools can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Segment indices, shared with the segment mux select decode.
  localparam logic [2:0] SEG_IF  = 3'd0;
  localparam logic [2:0] SEG_ID  = 3'd1;
  localparam logic [2:0] SEG_EX  = 3'd2;
  localparam logic [2:0] SEG_MEM = 3'd3;
  localparam logic [2:0] SEG_WB  = 3'd4;
  localparam logic [2:0] SEG_HZD = 3'd5;

  // Number of segments on the mux and width of the settle counter.
  localparam int SEG_COUNT = 6;
  localparam int CNT_W     = 4;

endpackage

`default_nettype wire

// File: rtl/check_snap_buf.sv
// ============================================================================
// Module   : check_snap_buf
// Brief    : NUM_SEG x DATA_W snapshot register file, one synchronous write
//            port and one combinational read port, cleared on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module check_snap_buf #(
  parameter int NUM_SEG = 6,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_SEG];

  // Storage: clear on reset, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SEG; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
        mem_q[i] <= wr_data_i;
      end
    end
  end

  // Read port: out-of-range addresses read as zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/check_scan_ctrl.sv
// ============================================================================
// Module   : check_scan_ctrl
// Brief    : Sequencer/arbiter for the debug check-data segment mux. Passes
//            the manual address through while idle, scans all segments into
//            a snapshot buffer on start, then streams it over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module check_scan_ctrl
  import check_scan_ctrl_pkg::*;
#(
  parameter int NUM_SEG = SEG_COUNT,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int SETTLE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] manual_addr_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] check_data_i,
  output logic [ADDR_W-1:0] check_addr_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              done_q,  done_d;
  logic              wr_en;
  logic              idx_last;

  assign idx_last = (idx_q == ADDR_W'(NUM_SEG - 1));

  // State, index, settle counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: abort always returns to IDLE without a done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE)) begin
          // Address has been stable long enough: capture this segment.
          wr_en = 1'b1;
          cnt_d = '0;
          if (idx_last) begin
            state_d = ST_SEND;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (out_ready_i) begin
          if (idx_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  check_snap_buf #(
    .NUM_SEG (NUM_SEG),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_snap_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q),
    .wr_data_i (check_data_i),
    .rd_addr_i (idx_q),
    .rd_data_o (out_data_o)
  );

  // The mux is owned only during SCAN; otherwise the manual address passes.
  assign check_addr_o = (state_q == ST_SCAN) ? idx_q : manual_addr_i;
  assign out_valid_o  = (state_q == ST_SEND);
  assign out_idx_o    = idx_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_check_scan_ctrl.sv
// ============================================================================
// Module   : tb_check_scan_ctrl
// Brief    : Randomized self-checking bench for check_scan_ctrl. Two
//            instances (SETTLE=1 and SETTLE=0) share stimulus; sel picks
//            which one receives start and is observed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_check_scan_ctrl;

  localparam int NSEG = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        out_ready;
  logic [2:0]  manual_addr;
  logic        sel;
  logic [31:0] base;

  int n_checks = 0;
  int n_errors = 0;

  // Instance with SETTLE=1
  logic [2:0]  ca1, oi1;
  logic [31:0] od1, cd1;
  logic        ov1, busy1, done1, st1;
  // Instance with SETTLE=0
  logic [2:0]  ca0, oi0;
  logic [31:0] od0, cd0;
  logic        ov0, busy0, done0, st0;

  // Segment mux model: each segment returns base + its address.
  assign cd1 = base + {29'd0, ca1};
  assign cd0 = base + {29'd0, ca0};
  assign st1 = start & ~sel;
  assign st0 = start & sel;

  check_scan_ctrl #(.NUM_SEG(NSEG), .ADDR_W(3), .DATA_W(32), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .manual_addr_i(manual_addr), .start_i(st1),
    .abort_i(abort), .check_data_i(cd1), .check_addr_o(ca1),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .out_idx_o(oi1), .busy_o(busy1), .done_o(done1)
  );

  check_scan_ctrl #(.NUM_SEG(NSEG), .ADDR_W(3), .DATA_W(32), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .manual_addr_i(manual_addr), .start_i(st0),
    .abort_i(abort), .check_data_i(cd0), .check_addr_o(ca0),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
    .out_idx_o(oi0), .busy_o(busy0), .done_o(done0)
  );

  // Observed view of the selected instance
  wire [2:0]  ca   = sel ? ca0   : ca1;
  wire [2:0]  oi   = sel ? oi0   : oi1;
  wire [31:0] od   = sel ? od0   : od1;
  wire        ov   = sel ? ov0   : ov1;
  wire        busy = sel ? busy0 : busy1;
  wire        done = sel ? done0 : done1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks a scan + stream that has just started; entered at the negedge of
  // the first SCAN cycle, returns at the negedge of the done cycle.
  // mode 0: ready always high, 1: random ready, 2: 4-cycle stall on word 2.
  task automatic scan_body(input int mode, input bit restart);
    int settle_v, scan_cyc, sent, stalls, cyc, stall2, busy_cnt;
    bit rdy;
    settle_v = sel ? 0 : 1;
    scan_cyc = NSEG * (settle_v + 1);
    busy_cnt = 0;
    for (int k = 0; k < scan_cyc; k++) begin
      check("scan_addr", {29'd0, ca}, k / (settle_v + 1));
      check("scan_busy", {31'd0, busy}, 1);
      check("scan_valid", {31'd0, ov}, 0);
      busy_cnt += int'(busy);
      @(negedge clk);
    end
    sent = 0; stalls = 0; cyc = 0; stall2 = 0;
    while (sent < NSEG && cyc < 200) begin
      check("send_valid", {31'd0, ov}, 1);
      check("send_idx", {29'd0, oi}, sent);
      check("send_data", od, base + sent);
      check("send_mux_released", {29'd0, ca}, {29'd0, manual_addr});
      check("send_done_low", {31'd0, done}, 0);
      busy_cnt += int'(busy);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 1) == 1);
        default: begin
          rdy = !(sent == 2 && stall2 < 4);
          if (!rdy) stall2++;
        end
      endcase
      if (!rdy) stalls++;
      out_ready   = rdy;
      start       = restart && (cyc == 0);
      manual_addr = 3'($urandom_range(0, 7));
      @(negedge clk);
      start = 1'b0;
      if (rdy) sent++;
      cyc++;
    end
    if (cyc >= 200) check("stream_timeout", 0, 1);
    out_ready = 1'b0;
    check("done_pulse", {31'd0, done}, 1);
    check("done_busy", {31'd0, busy}, 0);
    check("done_valid", {31'd0, ov}, 0);
    check("busy_len", busy_cnt, scan_cyc + NSEG + stalls);
  endtask

  task automatic pulse_start();
    base  = $urandom;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input int mode, input bit restart);
    pulse_start();
    scan_body(mode, restart);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);
  endtask

  // Advance until the selected instance shows out_valid, bounded.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ov) check("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    manual_addr = 3'd0; sel = 1'b0; base = 32'hA000_0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values and manual pass-through on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_valid", {31'd0, ov}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_data", od, 0);
      check("rst_idx", {29'd0, oi}, 0);
      manual_addr = 3'd3;
      #1;
      check("manual_addr3", {29'd0, ca}, 3);
      for (int i = 0; i < 4; i++) begin
        manual_addr = 3'($urandom_range(0, 7));
        #1;
        check("manual_pass", {29'd0, ca}, {29'd0, manual_addr});
      end
    end
    sel = 1'b0;

    // Directed full scan with the reference data pattern
    base = 32'hA000_0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    scan_body(0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);

    // Backpressure on word 2
    run_scan(2, 1'b0);

    // Second start during SEND is ignored
    run_scan(1, 1'b1);

    // New start coinciding with done is honoured
    pulse_start();
    scan_body(0, 1'b0);
    base  = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scan_body(1, 1'b0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);

    // Abort mid-scan at address 2
    pulse_start();
    begin
      int n;
      n = 0;
      while (ca != 3'd2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_addr2", {29'd0, ca}, 2);
    end
    abort = 1'b1; manual_addr = 3'd5;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, ov}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_addr", {29'd0, ca}, 5);
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 0);
    run_scan(0, 1'b0);

    // Abort during SEND
    pulse_start();
    wait_valid();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_send_busy", {31'd0, busy}, 0);
    check("abort_send_valid", {31'd0, ov}, 0);
    @(negedge clk);
    check("abort_send_no_done", {31'd0, done}, 0);

    // start and abort together in IDLE: abort wins
    manual_addr = 3'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 0);
    check("start_abort_addr", {29'd0, ca}, 4);

    // Reset during SEND
    pulse_start();
    wait_valid();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("pre_rst_idx", {29'd0, oi}, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_send_valid", {31'd0, ov}, 0);
    check("rst_send_busy", {31'd0, busy}, 0);
    check("rst_send_data", od, 0);
    check("rst_send_idx", {29'd0, oi}, 0);
    check("rst_send_done", {31'd0, done}, 0);
    @(negedge clk);
    check("rst_send_no_done", {31'd0, done}, 0);

    // SETTLE=0 instance: directed then random
    sel = 1'b1;
    run_scan(0, 1'b0);
    run_scan(2, 1'b0);

    // Randomized scans across both instances
    for (int r = 0; r < 12; r++) begin
      sel = ($urandom_range(0, 1) == 1);
      run_scan(int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
